two_level_cnt_ts: RTL and testbench

- Parametrised, registered two-level counter: an LSB tick counter with a runtime-programmable wrap value and an MSB rollover counter.
- Adds synchronous clear, preset load, a sticky out-of-range error and wrap pulses.
- Adds a sequential timestamp-delta engine: it reports the tick distance between successive mark events.
- Sits in the timing/trigger path, feeding event timestamps and inter-event distances to readout.

---
 rtl/two_level_cnt_pkg.sv | 19 +
 rtl/cnt_delta_acc.sv | 125 ++++++++++++
 rtl/two_level_cnt_ts.sv | 108 ++++++++++
 tb/tb_two_level_cnt_ts.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/two_level_cnt_pkg.sv
// Shared types and default sizing for the two-level tick counter and its
// timestamp-delta engine.
package two_level_cnt_pkg;

   localparam int LSB_W_DEF   = 12;
   localparam int MSB_W_DEF   = 3;
   localparam int LSB_MAX_DEF = 3563;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } delta_st_t;

   typedef struct packed {
      logic [MSB_W_DEF-1:0] msb;
      logic [LSB_W_DEF-1:0] lsb;
   } ts_pair_t;

endpackage

// File: rtl/cnt_delta_acc.sv
// Mark capture and delta accumulation: measures the tick distance between
// successive accepted marks, one MSB step per cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a mark; first mark after reset/clear only captures
// ACCUM | adding one LSB period per remaining MSB step, then report delta
module cnt_delta_acc
   import two_level_cnt_pkg::*;
#(
   parameter int LSB_W   = LSB_W_DEF,
   parameter int MSB_W   = MSB_W_DEF,
   parameter int DELTA_W = LSB_W + MSB_W + 1
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               clr_i,
   input  logic               mark_i,
   input  logic [LSB_W-1:0]   lsb_i,
   input  logic [MSB_W-1:0]   msb_i,
   input  logic [LSB_W-1:0]   lsb_max_i,
   output logic               busy_o,
   output logic               delta_valid_o,
   output logic [DELTA_W-1:0] delta_o
);

   localparam int ACC_W = DELTA_W + 1;

   delta_st_t                 state_q, state_d;
   logic                      have_prev_q, have_prev_d;
   logic [LSB_W-1:0]          prev_lsb_q, prev_lsb_d;
   logic [MSB_W-1:0]          prev_msb_q, prev_msb_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [MSB_W:0]            steps_q, steps_d;
   logic [LSB_W-1:0]          max_s_q, max_s_d;
   logic [DELTA_W-1:0]        delta_q, delta_d;
   logic                      valid_q, valid_d;

   logic                      mark_ok;
   logic [MSB_W-1:0]          msb_diff;
   logic [MSB_W:0]            steps_init;

   always_comb begin
      mark_ok    = mark_i && (lsb_i <= lsb_max_i);
      msb_diff   = msb_i - prev_msb_q;
      steps_init = {1'b0, msb_diff};
      // Same MSB but earlier LSB means a full MSB period has elapsed.
      if (msb_diff == '0 && lsb_i < prev_lsb_q)
         steps_init = {1'b1, {MSB_W{1'b0}}};
   end

   always_comb begin
      state_d     = state_q;
      have_prev_d = have_prev_q;
      prev_lsb_d  = prev_lsb_q;
      prev_msb_d  = prev_msb_q;
      acc_d       = acc_q;
      steps_d     = steps_q;
      max_s_d     = max_s_q;
      delta_d     = delta_q;
      valid_d     = 1'b0;
      if (clr_i) begin
         state_d     = IDLE;
         have_prev_d = 1'b0;
         prev_lsb_d  = '0;
         prev_msb_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mark_ok) begin
                  prev_lsb_d  = lsb_i;
                  prev_msb_d  = msb_i;
                  have_prev_d = 1'b1;
                  if (have_prev_q) begin
                     acc_d   = $signed(ACC_W'(lsb_i)) - $signed(ACC_W'(prev_lsb_q));
                     steps_d = steps_init;
                     max_s_d = lsb_max_i;
                     state_d = ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (steps_q != '0) begin
                  acc_d   = acc_q + $signed(ACC_W'(max_s_q) + ACC_W'(1));
                  steps_d = steps_q - (MSB_W+1)'(1);
               end else begin
                  delta_d = acc_q[DELTA_W-1:0];
                  valid_d = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         have_prev_q <= 1'b0;
         prev_lsb_q  <= '0;
         prev_msb_q  <= '0;
         acc_q       <= '0;
         steps_q     <= '0;
         max_s_q     <= '0;
         delta_q     <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         have_prev_q <= have_prev_d;
         prev_lsb_q  <= prev_lsb_d;
         prev_msb_q  <= prev_msb_d;
         acc_q       <= acc_d;
         steps_q     <= steps_d;
         max_s_q     <= max_s_d;
         delta_q     <= delta_d;
         valid_q     <= valid_d;
      end
   end

   assign busy_o        = (state_q == ACCUM);
   assign delta_valid_o = valid_q;
   assign delta_o       = delta_q;

endmodule

// File: rtl/two_level_cnt_ts.sv
// Two-level tick counter (programmable LSB wrap, MSB rollover) with sticky
// range error, wrap pulse and an attached timestamp-delta engine.
module two_level_cnt_ts
   import two_level_cnt_pkg::*;
#(
   parameter int LSB_W       = LSB_W_DEF,
   parameter int MSB_W       = MSB_W_DEF,
   parameter int LSB_MAX_RST = LSB_MAX_DEF,
   parameter int DELTA_W     = LSB_W + MSB_W + 1
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               en_i,
   input  logic               clr_i,
   input  logic               load_i,
   input  logic [LSB_W-1:0]   load_lsb_i,
   input  logic [MSB_W-1:0]   load_msb_i,
   input  logic               lsb_max_we_i,
   input  logic [LSB_W-1:0]   lsb_max_i,
   input  logic               err_clr_i,
   input  logic               mark_i,
   output logic [LSB_W-1:0]   lsb_cnt_o,
   output logic [MSB_W-1:0]   msb_cnt_o,
   output logic               wrap_o,
   output logic               lsb_cnt_err_o,
   output logic               busy_o,
   output logic               delta_valid_o,
   output logic [DELTA_W-1:0] delta_o
);

   logic [LSB_W-1:0] lsb_q;
   logic [MSB_W-1:0] msb_q;
   logic [LSB_W-1:0] lsb_max_q;
   logic             wrap_q;
   logic             err_q;
   logic             err_set;

   assign err_set = (lsb_q > lsb_max_q);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lsb_q  <= '0;
         msb_q  <= '0;
         wrap_q <= 1'b0;
      end else if (clr_i) begin
         lsb_q  <= '0;
         msb_q  <= '0;
         wrap_q <= 1'b0;
      end else if (load_i) begin
         lsb_q  <= load_lsb_i;
         msb_q  <= load_msb_i;
         wrap_q <= 1'b0;
      end else if (en_i) begin
         wrap_q <= 1'b0;
         if (lsb_q == lsb_max_q) begin
            lsb_q  <= '0;
            msb_q  <= msb_q + MSB_W'(1);
            wrap_q <= 1'b1;
         end else if (!err_set) begin
            lsb_q <= lsb_q + LSB_W'(1);
         end
      end else begin
         wrap_q <= 1'b0;
      end
   end

   // A live out-of-range condition beats a same-cycle error clear.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         err_q <= 1'b0;
      else if (clr_i)
         err_q <= 1'b0;
      else if (err_set)
         err_q <= 1'b1;
      else if (err_clr_i)
         err_q <= 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         lsb_max_q <= LSB_W'(LSB_MAX_RST);
      else if (lsb_max_we_i)
         lsb_max_q <= lsb_max_i;
   end

   cnt_delta_acc #(
      .LSB_W   (LSB_W),
      .MSB_W   (MSB_W),
      .DELTA_W (DELTA_W)
   ) u_delta (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .clr_i         (clr_i),
      .mark_i        (mark_i),
      .lsb_i         (lsb_q),
      .msb_i         (msb_q),
      .lsb_max_i     (lsb_max_q),
      .busy_o        (busy_o),
      .delta_valid_o (delta_valid_o),
      .delta_o       (delta_o)
   );

   assign lsb_cnt_o     = lsb_q;
   assign msb_cnt_o     = msb_q;
   assign wrap_o        = wrap_q;
   assign lsb_cnt_err_o = err_q;

endmodule

// File: tb/tb_two_level_cnt_ts.sv
// Directed and randomized checks of the two-level counter and delta engine
// against expectations derived from absolute tick positions.
module tb_two_level_cnt_ts;
   import two_level_cnt_pkg::*;

   localparam int LW = LSB_W_DEF;
   localparam int MW = MSB_W_DEF;
   localparam int DW = LW + MW + 1;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic          en_i, clr_i, load_i, lsb_max_we_i, err_clr_i, mark_i;
   logic [LW-1:0] load_lsb_i, lsb_max_i;
   logic [MW-1:0] load_msb_i;
   logic [LW-1:0] lsb_cnt_o;
   logic [MW-1:0] msb_cnt_o;
   logic          wrap_o, lsb_cnt_err_o, busy_o, delta_valid_o;
   logic [DW-1:0] delta_o;

   int n_assert = 0;
   int n_fail   = 0;

   two_level_cnt_ts dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .en_i          (en_i),
      .clr_i         (clr_i),
      .load_i        (load_i),
      .load_lsb_i    (load_lsb_i),
      .load_msb_i    (load_msb_i),
      .lsb_max_we_i  (lsb_max_we_i),
      .lsb_max_i     (lsb_max_i),
      .err_clr_i     (err_clr_i),
      .mark_i        (mark_i),
      .lsb_cnt_o     (lsb_cnt_o),
      .msb_cnt_o     (msb_cnt_o),
      .wrap_o        (wrap_o),
      .lsb_cnt_err_o (lsb_cnt_err_o),
      .busy_o        (busy_o),
      .delta_valid_o (delta_valid_o),
      .delta_o       (delta_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic load_pos(input int msb, input int lsb);
      load_i = 1'b1; load_msb_i = MW'(msb); load_lsb_i = LW'(lsb);
      tick();
      load_i = 1'b0;
   endtask

   // Fires a mark and watches the following window for busy/valid/delta.
   task automatic mark_delta(input string tag, input int exp_d, input int exp_steps, input bit drop);
      int busy_n = 0, valid_n = 0, valid_at = -1;
      logic [31:0] d_seen = '0;
      mark_i = 1'b1;
      tick();
      mark_i = 1'b0;
      for (int k = 0; k < exp_steps + 5; k++) begin
         if (busy_o) busy_n++;
         if (delta_valid_o) begin
            valid_n++;
            if (valid_at < 0) valid_at = k;
            d_seen = 32'(delta_o);
         end
         if (drop && k == 0) begin load_i = 1'b1; load_msb_i = 3'd1; load_lsb_i = LW'(5); end
         if (drop && k == 1) begin load_i = 1'b0; mark_i = 1'b1; end
         if (drop && k == 2) mark_i = 1'b0;
         tick();
      end
      chk({tag, "_busy_cycles"}, busy_n, exp_steps + 1);
      chk({tag, "_valid_at"}, valid_at, exp_steps + 1);
      chk({tag, "_valid_count"}, valid_n, 1);
      chk({tag, "_delta"}, d_seen, exp_d);
   endtask

   initial begin
      int wraps, cnt_v, cnt_b;
      int m_max, per, t, prev_t, have_prev, cyc, b_start, b_end, v_cyc, v_d;
      int lsb_pre, d, st;
      bit wrap_e;

      rst_n_i = 1'b0; en_i = 0; clr_i = 0; load_i = 0; lsb_max_we_i = 0;
      err_clr_i = 0; mark_i = 0; load_lsb_i = '0; load_msb_i = '0; lsb_max_i = '0;
      repeat (2) @(negedge clk_i);
      chk("rst_lsb", 32'(lsb_cnt_o), 0);
      chk("rst_msb", 32'(msb_cnt_o), 0);
      chk("rst_flags", {wrap_o, lsb_cnt_err_o, busy_o, delta_valid_o}, 0);
      chk("rst_delta", 32'(delta_o), 0);
      rst_n_i = 1'b1;

      // Free-run through the default wrap point
      en_i = 1'b1; wraps = 0;
      for (int i = 0; i < 3563; i++) begin tick(); if (wrap_o) wraps++; end
      chk("run_lsb_at_max", 32'(lsb_cnt_o), 3563);
      chk("run_msb_before_wrap", 32'(msb_cnt_o), 0);
      tick(); if (wrap_o) wraps++;
      chk("wrap_lsb", 32'(lsb_cnt_o), 0);
      chk("wrap_msb", 32'(msb_cnt_o), 1);
      chk("wrap_pulse", 32'(wrap_o), 1);
      tick(); if (wrap_o) wraps++;
      chk("wrap_pulse_end", 32'(wrap_o), 0);
      chk("wrap_count", wraps, 1);
      chk("run_err", 32'(lsb_cnt_err_o), 0);

      // Out-of-range preset and sticky error
      load_pos(0, 4000);
      chk("oor_loaded", 32'(lsb_cnt_o), 4000);
      tick();
      chk("oor_hold", 32'(lsb_cnt_o), 4000);
      chk("oor_err_set", 32'(lsb_cnt_err_o), 1);
      err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
      chk("oor_err_clr_loses", 32'(lsb_cnt_err_o), 1);
      load_pos(0, 0);
      err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
      chk("oor_err_cleared", 32'(lsb_cnt_err_o), 0);

      // Delta with max=9: (0,3) -> (2,1)
      en_i = 1'b0; clr_i = 1'b1; lsb_max_we_i = 1'b1; lsb_max_i = LW'(9);
      tick();
      clr_i = 1'b0; lsb_max_we_i = 1'b0; en_i = 1'b1;
      repeat (3) tick();
      mark_i = 1'b1; tick(); mark_i = 1'b0;
      repeat (17) tick();
      en_i = 1'b0;
      chk("d18_pos", {16'(msb_cnt_o), 16'(lsb_cnt_o)}, {16'd2, 16'd1});
      mark_delta("d18", 18, 2, 1'b0);

      // MSB rollover (7,8) -> (1,2), with a mark dropped while busy
      clr_i = 1'b1; tick(); clr_i = 1'b0;
      load_pos(7, 8);
      mark_i = 1'b1; tick(); mark_i = 1'b0;
      load_pos(1, 2);
      mark_delta("d14", 14, 2, 1'b1);
      load_pos(1, 7);
      mark_delta("d5_after_drop", 5, 0, 1'b0);

      // Full MSB period: (0,5) -> 79 ticks later at (0,4)
      clr_i = 1'b1; tick(); clr_i = 1'b0;
      load_pos(0, 5);
      mark_i = 1'b1; tick(); mark_i = 1'b0;
      en_i = 1'b1; repeat (79) tick(); en_i = 1'b0;
      chk("d79_pos", {16'(msb_cnt_o), 16'(lsb_cnt_o)}, {16'd0, 16'd4});
      mark_delta("d79", 79, 8, 1'b0);

      // Clear while accumulating
      load_pos(3, 0);
      mark_i = 1'b1; tick(); mark_i = 1'b0;
      chk("clr_pre_busy", 32'(busy_o), 1);
      clr_i = 1'b1; tick(); clr_i = 1'b0;
      chk("clr_busy", 32'(busy_o), 0);
      chk("clr_lsb", 32'(lsb_cnt_o), 0);
      cnt_v = 0; cnt_b = 0;
      repeat (8) begin if (delta_valid_o) cnt_v++; tick(); end
      mark_i = 1'b1; tick(); mark_i = 1'b0;
      repeat (8) begin if (delta_valid_o) cnt_v++; if (busy_o) cnt_b++; tick(); end
      chk("clr_no_valid", cnt_v, 0);
      chk("clr_first_mark_no_busy", cnt_b, 0);

      // Async reset mid-count
      en_i = 1'b1; repeat (20) tick();
      @(posedge clk_i); #2 rst_n_i = 1'b0; #1;
      chk("arst_cnt", {16'(msb_cnt_o), 16'(lsb_cnt_o)}, 0);
      chk("arst_flags", {wrap_o, lsb_cnt_err_o, busy_o, delta_valid_o}, 0);
      chk("arst_delta", 32'(delta_o), 0);
      @(negedge clk_i); rst_n_i = 1'b1; en_i = 1'b0;

      // Randomized run against a tick-position model
      m_max = $urandom_range(4, 12); per = m_max + 1;
      lsb_max_we_i = 1'b1; lsb_max_i = LW'(m_max); clr_i = 1'b1;
      tick();
      lsb_max_we_i = 1'b0; clr_i = 1'b0;
      t = 0; prev_t = 0; have_prev = 0; cyc = 0;
      b_start = -100; b_end = 0; v_cyc = -1; v_d = 0;
      for (int i = 0; i < 600; i++) begin
         en_i   = ($urandom % 4) != 0;
         mark_i = ($urandom % 6) == 0;
         @(posedge clk_i);
         cyc++;
         lsb_pre = t % per;
         if (mark_i && cyc >= b_end) begin
            if (have_prev != 0) begin
               d  = ((t % (8 * per)) - (prev_t % (8 * per)) + 8 * per) % (8 * per);
               st = (((t / per) % 8) - ((prev_t / per) % 8) + 8) % 8;
               if (st == 0 && lsb_pre < prev_t % per) st = 8;
               v_cyc = cyc + st + 1; v_d = d;
               b_start = cyc; b_end = cyc + st + 2;
            end
            prev_t = t; have_prev = 1;
         end
         wrap_e = en_i && (lsb_pre == m_max);
         if (en_i) t++;
         @(negedge clk_i);
         chk("rnd_lsb", 32'(lsb_cnt_o), t % per);
         chk("rnd_msb", 32'(msb_cnt_o), (t / per) % 8);
         chk("rnd_wrap", 32'(wrap_o), 32'(wrap_e));
         chk("rnd_busy", 32'(busy_o), 32'(cyc >= b_start && cyc < b_end - 1));
         chk("rnd_valid", 32'(delta_valid_o), 32'(cyc == v_cyc));
         if (cyc == v_cyc) chk("rnd_delta", 32'(delta_o), v_d);
      end
      mark_i = 1'b0; en_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
